// File: rtl/recur_state_ctrl.sv
// recur_state_ctrl: turns recursion call/return events into appends and parent lookups on the InexRecur state regfile.
// Define STATE_READBACK_CHK_EN to add a readback check of every pushed word (CHK state, chk_err).
module recur_state_ctrl #(
   parameter int DEPTH        = 4096,
   parameter int PARENT_LIMIT = 2048
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        call_valid,
   output logic        call_ready,
   input  logic [3:0]  call_pos,
   input  logic        ret_valid,
   output logic        ret_ready,
   output logic        resume_valid,
   input  logic        resume_ready,
   output logic [3:0]  resume_pos,
   output logic [10:0] resume_addr,
   output logic        resume_term,
   output logic [11:0] cur_idx,
   output logic        active,
   output logic        err_ovf,
   output logic        err_addr,
   output logic        err_ret,
   output logic        chk_err,
   output logic        rf_we,
   output logic [15:0] rf_w_data,
   output logic        rf_seq_re,
   input  logic [15:0] rf_seq_r_data,
   input  logic [11:0] rf_out_r_addr,
   output logic        rf_ran_re,
   output logic [11:0] rf_ran_r_addr,
   input  logic [15:0] rf_ran_r_data
);

   typedef enum logic [2:0] {IDLE, PUSH, POP_RD, RESUME, CHK} state_t;

   state_t      state_q;
   state_t      state_d;
   logic [12:0] count;
   logic        in_idle;
   logic        call_fire;
   logic        ret_fire;
   logic        refuse_ovf;
   logic        refuse_addr;
   logic [15:0] call_word;

   assign in_idle     = (state_q == IDLE);
   assign ret_ready   = in_idle;
   assign call_ready  = in_idle && !ret_valid;
   assign call_fire   = call_valid && call_ready;
   assign ret_fire    = ret_valid && ret_ready;
   assign refuse_ovf  = (count == 13'(DEPTH));
   assign refuse_addr = active && (cur_idx >= 12'(PARENT_LIMIT));
   assign call_word   = active ? {call_pos, cur_idx[10:0], 1'b0} : {call_pos, 11'd0, 1'b1};

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // A return always beats a simultaneous call; a refused call leaves the FSM idle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (ret_fire) begin
               if (active) state_d = POP_RD;
            end else if (call_fire && !refuse_ovf && !refuse_addr) begin
               state_d = PUSH;
            end
         end
`ifdef STATE_READBACK_CHK_EN
         PUSH:    state_d = CHK;
         CHK:     state_d = IDLE;
`else
         PUSH:    state_d = IDLE;
`endif
         POP_RD:  state_d = RESUME;
         RESUME:  if (resume_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count         <= '0;
         cur_idx       <= '0;
         active        <= 1'b0;
         err_ovf       <= 1'b0;
         err_addr      <= 1'b0;
         err_ret       <= 1'b0;
         rf_we         <= 1'b0;
         rf_w_data     <= '0;
         rf_ran_re     <= 1'b0;
         rf_ran_r_addr <= '0;
         resume_valid  <= 1'b0;
         resume_pos    <= '0;
         resume_addr   <= '0;
         resume_term   <= 1'b0;
      end else begin
         rf_we     <= 1'b0;
         rf_ran_re <= 1'b0;
         case (state_q)
            IDLE: begin
               if (ret_fire) begin
                  if (active) begin
                     rf_ran_re     <= 1'b1;
                     rf_ran_r_addr <= cur_idx;
                  end else begin
                     err_ret <= 1'b1;
                  end
               end else if (call_fire) begin
                  if (refuse_ovf)  err_ovf  <= 1'b1;
                  if (refuse_addr) err_addr <= 1'b1;
                  if (!refuse_ovf && !refuse_addr) begin
                     rf_we     <= 1'b1;
                     rf_w_data <= call_word;
                  end
               end
            end
            PUSH: begin
               cur_idx <= count[11:0];
               count   <= count + 13'd1;
               active  <= 1'b1;
            end
            // The parent word arrives combinationally while rf_ran_re is high.
            POP_RD: begin
               resume_valid <= 1'b1;
               resume_pos   <= rf_ran_r_data[15:12];
               if (rf_ran_r_data[0]) begin
                  resume_term <= 1'b1;
                  resume_addr <= '0;
                  active      <= 1'b0;
               end else begin
                  resume_term <= 1'b0;
                  resume_addr <= rf_ran_r_data[11:1];
                  cur_idx     <= {1'b0, rf_ran_r_data[11:1]};
               end
            end
            RESUME: begin
               if (resume_ready) resume_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

`ifdef STATE_READBACK_CHK_EN
   // rf_w_data still holds the pushed word and cur_idx its index during CHK.
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_seq_re <= 1'b0;
         chk_err   <= 1'b0;
      end else begin
         rf_seq_re <= (state_q == PUSH);
         if (state_q == CHK && (rf_seq_r_data != rf_w_data || rf_out_r_addr != cur_idx))
            chk_err <= 1'b1;
      end
   end
`else
   logic unused_seq_inputs;
   assign unused_seq_inputs = ^{rf_seq_r_data, rf_out_r_addr};
   assign rf_seq_re         = 1'b0;
   assign chk_err           = 1'b0;
`endif

endmodule

// File: tb/tb_recur_state_ctrl.sv
// tb_recur_state_ctrl: scoreboard bench for recur_state_ctrl with a regfile model and a frame-array reference model.
// Directed call/return/backpressure/error sequences followed by randomized traffic up to overflow.
module tb_recur_state_ctrl;

   localparam int DEPTH_T = 12;
   localparam int PL_T    = 5;

   logic        clk;
   logic        rst;
   logic        call_valid;
   logic        call_ready;
   logic [3:0]  call_pos;
   logic        ret_valid;
   logic        ret_ready;
   logic        resume_valid;
   logic        resume_ready;
   logic [3:0]  resume_pos;
   logic [10:0] resume_addr;
   logic        resume_term;
   logic [11:0] cur_idx;
   logic        active;
   logic        err_ovf;
   logic        err_addr;
   logic        err_ret;
   logic        chk_err;
   logic        rf_we;
   logic [15:0] rf_w_data;
   logic        rf_seq_re;
   logic [15:0] rf_seq_r_data;
   logic [11:0] rf_out_r_addr;
   logic        rf_ran_re;
   logic [11:0] rf_ran_r_addr;
   logic [15:0] rf_ran_r_data;

   recur_state_ctrl #(.DEPTH(DEPTH_T), .PARENT_LIMIT(PL_T)) dut (
      .clk(clk), .rst(rst),
      .call_valid(call_valid), .call_ready(call_ready), .call_pos(call_pos),
      .ret_valid(ret_valid), .ret_ready(ret_ready),
      .resume_valid(resume_valid), .resume_ready(resume_ready),
      .resume_pos(resume_pos), .resume_addr(resume_addr), .resume_term(resume_term),
      .cur_idx(cur_idx), .active(active),
      .err_ovf(err_ovf), .err_addr(err_addr), .err_ret(err_ret), .chk_err(chk_err),
      .rf_we(rf_we), .rf_w_data(rf_w_data),
      .rf_seq_re(rf_seq_re), .rf_seq_r_data(rf_seq_r_data), .rf_out_r_addr(rf_out_r_addr),
      .rf_ran_re(rf_ran_re), .rf_ran_r_addr(rf_ran_r_addr), .rf_ran_r_data(rf_ran_r_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Append-only regfile model; reset together with the controller.
   logic [15:0] mem [0:4095];
   logic [11:0] mem_ptr;
   always @(posedge clk) begin
      if (rst) mem_ptr <= '0;
      else if (rf_we) begin
         mem[mem_ptr] <= rf_w_data;
         mem_ptr      <= mem_ptr + 12'd1;
      end
   end
   assign rf_ran_r_data = mem[rf_ran_r_addr];
   assign rf_seq_r_data = '0;
   assign rf_out_r_addr = '0;

   typedef struct {
      logic [3:0]  pos;
      logic [10:0] addr;
      logic        term;
   } resume_t;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [15:0] wq [$];
   resume_t     rq [$];

   // Reference model: one frame per pushed call, linked to its parent frame.
   int m_count;
   int m_cur;
   bit m_active;
   bit e_ovf, e_addr, e_ret;
   int m_pos    [0:DEPTH_T-1];
   int m_parent [0:DEPTH_T-1];
   bit m_root   [0:DEPTH_T-1];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic note_fail(input string name);
      n_checks++;
      n_errors++;
      $display("[TB] FAIL %s: timed out waiting for DUT", name);
   endtask

   task automatic model_reset();
      m_count  = 0;
      m_cur    = 0;
      m_active = 0;
      e_ovf    = 0;
      e_addr   = 0;
      e_ret    = 0;
   endtask

   task automatic model_call(input logic [3:0] pos);
      bit refused;
      refused = 0;
      if (m_count == DEPTH_T) begin e_ovf = 1; refused = 1; end
      if (m_active && m_cur >= PL_T) begin e_addr = 1; refused = 1; end
      if (!refused) begin
         m_pos[m_count]    = int'(pos);
         m_parent[m_count] = m_active ? m_cur : 0;
         m_root[m_count]   = !m_active;
         wq.push_back({pos, 11'(m_parent[m_count]), m_root[m_count]});
         m_cur    = m_count;
         m_count  = m_count + 1;
         m_active = 1;
      end
   endtask

   task automatic model_ret(output resume_t r);
      r.pos  = '0;
      r.addr = '0;
      r.term = 1'b0;
      if (!m_active) begin
         e_ret = 1;
      end else begin
         r.pos = 4'(m_pos[m_cur]);
         if (m_root[m_cur]) begin
            r.term   = 1'b1;
            m_active = 0;
         end else begin
            r.addr = 11'(m_parent[m_cur]);
            m_cur  = m_parent[m_cur];
         end
         rq.push_back(r);
      end
   endtask

   // Monitor: pops expectations whenever the DUT writes the regfile or hands over resume info.
   initial begin
      logic [15:0] w;
      resume_t     r;
      forever begin
         @(negedge clk);
         if (!rst && rf_we) begin
            if (wq.size() == 0) note_fail("unexpected_rf_we");
            else begin
               w = wq.pop_front();
               check("rf_w_data", 32'(rf_w_data), 32'(w));
            end
         end
         if (!rst && resume_valid && resume_ready) begin
            if (rq.size() == 0) note_fail("unexpected_resume");
            else begin
               r = rq.pop_front();
               check("resume_pos", 32'(resume_pos), 32'(r.pos));
               check("resume_addr", 32'(resume_addr), 32'(r.addr));
               check("resume_term", 32'(resume_term), 32'(r.term));
            end
         end
      end
   end

   task automatic check_output();
      check("cur_idx", 32'(cur_idx), 32'(m_cur));
      check("active", 32'(active), 32'(m_active));
      check("err_ovf", 32'(err_ovf), 32'(e_ovf));
      check("err_addr", 32'(err_addr), 32'(e_addr));
      check("err_ret", 32'(err_ret), 32'(e_ret));
      check("chk_err", 32'(chk_err), 32'(0));
      check("rf_seq_re", 32'(rf_seq_re), 32'(0));
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      call_valid   = 1'b0;
      ret_valid    = 1'b0;
      resume_ready = 1'b1;
      call_pos     = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_cur_idx", 32'(cur_idx), 32'(0));
      check("rst_active", 32'(active), 32'(0));
      check("rst_errs", 32'({err_ovf, err_addr, err_ret, chk_err}), 32'(0));
      check("rst_rf_we", 32'(rf_we), 32'(0));
      check("rst_rf_w_data", 32'(rf_w_data), 32'(0));
      check("rst_rf_ran", 32'({rf_ran_re, rf_ran_r_addr}), 32'(0));
      check("rst_rf_seq_re", 32'(rf_seq_re), 32'(0));
      check("rst_resume", 32'({resume_valid, resume_pos, resume_addr, resume_term}), 32'(0));
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("idle_call_ready", 32'(call_ready), 32'(1));
      check("idle_ret_ready", 32'(ret_ready), 32'(1));
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin @(negedge clk); n++; end while (!ret_ready && n < 64);
      if (!ret_ready) note_fail("wait_idle");
   endtask

   task automatic finish_call();
      int n = 0;
      do begin @(negedge clk); n++; end while (!call_ready && n < 64);
      if (!call_ready) note_fail("call_ready_wait");
      @(posedge clk);
      model_call(call_pos);
      #1 call_valid = 1'b0;
      wait_idle();
      check_output();
   endtask

   task automatic finish_ret(input int bp);
      int          n = 0;
      bit          was_active;
      logic [11:0] exp_idx;
      resume_t     r;
      do begin @(negedge clk); n++; end while (!ret_ready && n < 64);
      if (!ret_ready) note_fail("ret_ready_wait");
      if (call_valid) check("call_ready_vs_ret", 32'(call_ready), 32'(0));
      @(posedge clk);
      was_active = m_active;
      exp_idx    = 12'(m_cur);
      model_ret(r);
      #1 ret_valid = 1'b0;
      @(negedge clk);
      if (!was_active) begin
         check("err_ret_set", 32'(err_ret), 32'(1));
         check("no_resume", 32'(resume_valid), 32'(0));
         return;
      end
      check("rf_ran_re", 32'(rf_ran_re), 32'(1));
      check("rf_ran_r_addr", 32'(rf_ran_r_addr), 32'(exp_idx));
      n = 0;
      while (!resume_valid && n < 64) begin @(negedge clk); n++; end
      if (!resume_valid) note_fail("resume_valid_wait");
      if (bp > 0) begin
         for (int i = 0; i < bp; i++) begin
            if (i > 0) @(negedge clk);
            check("bp_valid", 32'(resume_valid), 32'(1));
            check("bp_pos", 32'(resume_pos), 32'(r.pos));
            check("bp_addr", 32'(resume_addr), 32'(r.addr));
            check("bp_term", 32'(resume_term), 32'(r.term));
            check("bp_call_ready", 32'(call_ready), 32'(0));
         end
         @(posedge clk);
         #1 resume_ready = 1'b1;
         @(negedge clk);
      end
   endtask

   task automatic do_call(input logic [3:0] pos);
      @(posedge clk);
      #1 call_valid = 1'b1;
      call_pos = pos;
      finish_call();
   endtask

   task automatic do_ret(input int bp);
      @(posedge clk);
      #1 ret_valid = 1'b1;
      resume_ready = (bp == 0);
      finish_ret(bp);
      wait_idle();
      check_output();
   endtask

   // Call and return raised together while a recursion is active.
   task automatic do_both(input logic [3:0] pos);
      @(posedge clk);
      #1 call_valid = 1'b1;
      call_pos     = pos;
      ret_valid    = 1'b1;
      resume_ready = 1'b1;
      finish_ret(0);
      finish_call();
   endtask

   task automatic apply_stimulus();
      int sel;
      for (int it = 0; it < 80; it++) begin
         sel = int'($urandom_range(0, 9));
         if (sel < 5)                 do_call(4'($urandom_range(0, 15)));
         else if (sel < 9 || !m_active) do_ret(int'($urandom_range(0, 2)));
         else                         do_both(4'($urandom_range(0, 15)));
      end
      for (int it = 0; it < 100 && m_count < DEPTH_T; it++) begin
         if (m_active && m_cur >= PL_T) do_ret(0);
         else                          do_call(4'($urandom_range(0, 15)));
      end
      do_call(4'hA);
      check("err_ovf_final", 32'(err_ovf), 32'(1));
   endtask

   initial begin
      rst          = 1'b1;
      call_valid   = 1'b0;
      ret_valid    = 1'b0;
      resume_ready = 1'b1;
      call_pos     = '0;
      apply_reset();

      do_call(4'h3);
      do_call(4'h5);
      do_call(4'h7);
      do_ret(5);
      do_ret(0);
      do_both(4'h9);
      do_ret(0);
      do_ret(0);

      apply_reset();
      apply_stimulus();

      repeat (3) @(negedge clk);
      check("wq_drained", 32'(wq.size()), 32'(0));
      check("rq_drained", 32'(rq.size()), 32'(0));
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
